// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath side is the master; the controller uses the slave modport.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [15:0]      id_instr;
  logic             ex_redirect;
  logic             mem_busy;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_id;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_instr, ex_redirect, mem_busy,
    input  stall_if, stall_id, bubble_ex, flush_id,
    input  fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_instr, ex_redirect, mem_busy,
    output stall_if, stall_id, bubble_ex, flush_id,
    output fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage 16-bit pipeline: decodes ID, tracks in-flight
// destinations in EX/MEM/WB shadow slots and drives stall, bubble, flush and forwarding.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_if.slave   hz
);

  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       is_load;
  } slot_t;

  slot_t            ex_slot, mem_slot, wb_slot, id_slot;
  logic             rd_a, rd_b, wr, is_load, is_jump;
  logic [2:0]       src_a, src_b, dst;
  logic             load_use, redirect;
  logic [1:0]       fwd_a_next, fwd_b_next;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Decode the ID instruction into its register reads/write; r0 is filtered here
  always_comb begin
    rd_a    = 1'b0;
    rd_b    = 1'b0;
    wr      = 1'b0;
    is_load = 1'b0;
    is_jump = 1'b0;
    src_a   = hz.id_instr[11:9];
    src_b   = hz.id_instr[8:6];
    dst     = hz.id_instr[8:6];
    if (hz.id_valid) begin
      case (hz.id_instr[15:12])
        4'h0: begin
          rd_a  = 1'b1;
          rd_b  = 1'b1;
          wr    = 1'b1;
          src_a = hz.id_instr[8:6];
          src_b = hz.id_instr[5:3];
          dst   = hz.id_instr[11:9];
        end
        4'h1: is_jump = 1'b1;
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          rd_a = 1'b1;
          wr   = 1'b1;
        end
        4'h8: begin
          rd_a    = 1'b1;
          wr      = 1'b1;
          is_load = 1'b1;
        end
        4'h9, 4'hA, 4'hB: begin
          rd_a = 1'b1;
          rd_b = 1'b1;
        end
        default: ;
      endcase
    end
    if (R0_ZERO) begin
      if (dst == 3'd0)   wr   = 1'b0;
      if (src_a == 3'd0) rd_a = 1'b0;
      if (src_b == 3'd0) rd_b = 1'b0;
    end
  end

  always_comb begin
    id_slot.valid   = wr;
    id_slot.dst     = dst;
    id_slot.is_load = is_load;
    redirect = hz.ex_redirect && !hz.mem_busy;
    load_use = !hz.mem_busy && ex_slot.valid && ex_slot.is_load &&
               ((rd_a && ex_slot.dst == src_a) || (rd_b && ex_slot.dst == src_b));
  end

  // Nearer stage wins: EX producer forwards from MEM next cycle, MEM producer from WB
  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (rd_a && ex_slot.valid && ex_slot.dst == src_a)        fwd_a_next = 2'b01;
    else if (rd_a && mem_slot.valid && mem_slot.dst == src_a) fwd_a_next = 2'b10;
    if (rd_b && ex_slot.valid && ex_slot.dst == src_b)        fwd_b_next = 2'b01;
    else if (rd_b && mem_slot.valid && mem_slot.dst == src_b) fwd_b_next = 2'b10;
  end

  // Priority: mem_busy > redirect > load-use > jump
  always_comb begin
    hz.stall_if  = 1'b0;
    hz.stall_id  = 1'b0;
    hz.bubble_ex = 1'b0;
    hz.flush_id  = 1'b0;
    if (hz.mem_busy) begin
    end else if (redirect) begin
      hz.flush_id  = 1'b1;
      hz.bubble_ex = 1'b1;
    end else if (load_use) begin
      hz.stall_if  = 1'b1;
      hz.stall_id  = 1'b1;
      hz.bubble_ex = 1'b1;
    end else if (is_jump) begin
      hz.flush_id = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hz.mem_busy) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (hz.bubble_ex) begin
        ex_slot <= '0;
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end else begin
        ex_slot <= id_slot;
        fwd_a_q <= fwd_a_next;
        fwd_b_q <= fwd_b_next;
      end
      if (hz.stall_if && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (hz.flush_id && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.fwd_a_sel    = fwd_a_q;
  assign hz.fwd_b_sel    = fwd_b_q;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;

endmodule
